// File: rtl/halt_monitor_if.sv
// Bundle between the pipelined core and the halt/exit monitor.
// master: core side (drives ID/WB events and resume); slave: the monitor.
interface halt_monitor_if;

    // Core -> monitor
    logic        ebreak_pulse;
    logic        ecall_pulse;
    logic [31:0] id_pc;
    logic        wb_wen;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        retire_valid;
    logic        resume;

    // Monitor -> core / host
    logic        hold_fetch;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] halt_pc;
    logic [31:0] exit_code;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    modport master (
        output ebreak_pulse,
        output ecall_pulse,
        output id_pc,
        output wb_wen,
        output wb_rd_addr,
        output wb_data,
        output retire_valid,
        output resume,
        input  hold_fetch,
        input  halted,
        input  halt_cause,
        input  halt_pc,
        input  exit_code,
        input  cycle_cnt,
        input  instret_cnt
    );

    modport slave (
        input  ebreak_pulse,
        input  ecall_pulse,
        input  id_pc,
        input  wb_wen,
        input  wb_rd_addr,
        input  wb_data,
        input  retire_valid,
        input  resume,
        output hold_fetch,
        output halted,
        output halt_cause,
        output halt_pc,
        output exit_code,
        output cycle_cnt,
        output instret_cnt
    );

endinterface

// File: rtl/halt_monitor.sv
// Halt/exit monitor: on EBREAK/ECALL it freezes fetch, lets in-flight older
// instructions drain for DRAIN_CYCLES, then reports cause, halt PC, exit code
// (shadowed x10) and cycle/retired counters until resumed.
// Optional forced-timeout halt is built only when HALT_MONITOR_TIMEOUT_EN is
// defined; without it TIMEOUT_CYCLES is unused and cause 11 never occurs.
module halt_monitor #(
    parameter int unsigned DRAIN_CYCLES   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50
) (
    input  logic          clk,
    input  logic          rst,
    halt_monitor_if.slave bus
);

    localparam int unsigned DRAIN_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int unsigned CNT_W     = 64;
    localparam int unsigned XLEN      = 32;
    localparam logic [4:0]  EXIT_REG  = 5'd10;

    localparam logic [1:0]  CAUSE_NONE    = 2'b00;
    localparam logic [1:0]  CAUSE_EBREAK  = 2'b01;
    localparam logic [1:0]  CAUSE_ECALL   = 2'b10;
`ifdef HALT_MONITOR_TIMEOUT_EN
    localparam logic [1:0]  CAUSE_TIMEOUT = 2'b11;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES) - CNT_W'(1);
`endif

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Reject illegal parameterisations at elaboration.
    if (DRAIN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("halt_monitor: DRAIN_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    state_e             state_q;
    logic [DRAIN_W-1:0] drain_cnt_q;
    logic               hold_fetch_q;
    logic               halted_q;
    logic [1:0]         halt_cause_q;
    logic [XLEN-1:0]    halt_pc_q;
    logic [XLEN-1:0]    exit_code_q;
    logic [CNT_W-1:0]   cycle_cnt_q;
    logic [CNT_W-1:0]   instret_cnt_q;

    logic               pulse_c;
    logic               counting_c;
    logic               exit_wr_c;

    // Event decode: any halt request, counting window, and x10 write-back.
    assign pulse_c    = bus.ebreak_pulse | bus.ecall_pulse;
    assign counting_c = (state_q != ST_HALTED);
    assign exit_wr_c  = bus.wb_wen && (bus.wb_rd_addr == EXIT_REG);

    // Monitor FSM plus counters and captured halt information.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            drain_cnt_q   <= '0;
            hold_fetch_q  <= 1'b0;
            halted_q      <= 1'b0;
            halt_cause_q  <= CAUSE_NONE;
            halt_pc_q     <= '0;
            exit_code_q   <= '0;
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            // Counters and exit-code shadow only move while the core is live
            // (RUN or DRAIN); the halting edge itself is still counted.
            if (counting_c) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                if (bus.retire_valid) begin
                    instret_cnt_q <= instret_cnt_q + CNT_W'(1);
                end
                if (exit_wr_c) begin
                    exit_code_q <= bus.wb_data;
                end
            end

            unique case (state_q)
                ST_RUN: begin
                    if (pulse_c) begin
                        state_q      <= ST_DRAIN;
                        drain_cnt_q  <= DRAIN_W'(DRAIN_CYCLES);
                        hold_fetch_q <= 1'b1;
                        halt_cause_q <= bus.ebreak_pulse ? CAUSE_EBREAK : CAUSE_ECALL;
                        halt_pc_q    <= bus.id_pc;
                    end
`ifdef HALT_MONITOR_TIMEOUT_EN
                    // Budget exhausted with no pulse: halt at once, nothing to drain.
                    else if (cycle_cnt_q == TIMEOUT_LAST) begin
                        state_q      <= ST_HALTED;
                        halted_q     <= 1'b1;
                        hold_fetch_q <= 1'b1;
                        halt_cause_q <= CAUSE_TIMEOUT;
                        halt_pc_q    <= bus.id_pc;
                    end
`endif
                end

                ST_DRAIN: begin
                    // Further pulses are ignored; wait for older instructions to land.
                    drain_cnt_q <= drain_cnt_q - DRAIN_W'(1);
                    if (drain_cnt_q == DRAIN_W'(1)) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end

                ST_HALTED: begin
                    // halt_pc, exit_code and counters are retained across resume.
                    if (bus.resume) begin
                        state_q      <= ST_RUN;
                        halted_q     <= 1'b0;
                        hold_fetch_q <= 1'b0;
                        halt_cause_q <= CAUSE_NONE;
                    end
                end

                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // All outputs come straight from registers.
    assign bus.hold_fetch  = hold_fetch_q;
    assign bus.halted      = halted_q;
    assign bus.halt_cause  = halt_cause_q;
    assign bus.halt_pc     = halt_pc_q;
    assign bus.exit_code   = exit_code_q;
    assign bus.cycle_cnt   = cycle_cnt_q;
    assign bus.instret_cnt = instret_cnt_q;

endmodule
